unique_list_serializer: RTL and testbench
=========================================

// Module: unique_list_serializer
// PURPOSE
// - Downstream stage of the sort/dedup block: captures one sorted, de-duplicated list (values + unique count) and emits it one element per beat on a valid/ready stream.
// - Sits between the parallel sort/dedup result and narrow consumers (UART/TX framing, histogram logic).
// - Holds a snapshot, so upstream may change its outputs every clock without corrupting a transfer in progress.
// PARAMETERS
// - WIDTH  8  bits per element
// - DEPTH  9  max elements per list
// - CW     4  count width, = $clog2(DEPTH+1)
// PORTS
// - clk         in   1            rising-edge clock (single clock domain)
// - rst         in   1            synchronous, active-high reset
// - load_valid  in   1            in_data/in_count hold a new list this cycle
// - load_ready  out  1            1 when IDLE; a list is accepted on load_valid & load_ready
// - in_data     in   DEPTH*WIDTH  element k (k=0 smallest) at [k*WIDTH +: WIDTH]
// - in_count    in   CW           number of valid elements (unique count)
// - out_valid   out  1            out_data/out_last/out_index valid
// - out_ready   in   1            consumer accepts the beat
// - out_data    out  WIDTH        current element
// - out_index   out  CW           0-based position of the current element
// - out_last    out  1            current element is the final one of the list
// - busy        out  1            list in flight (state SEND)
// - empty_pulse out  1            1-cycle pulse: accepted list had count 0
// - drop_pulse  out  1            1-cycle pulse: load_valid arrived while busy, list discarded
// BEHAVIOUR
// - Reset (sync, rst=1 at the clock edge): state=IDLE, load_ready=1, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, empty_pulse=0, drop_pulse=0, snapshot regs=0.
// - FSM states: IDLE, SEND.
//   - IDLE -> SEND: load accepted with eff_count>0. The snapshot is captured on the same edge.
//   - IDLE -> IDLE: load accepted with eff_count=0. empty_pulse=1 in the next cycle; nothing is emitted.
//   - SEND -> SEND: out_valid & out_ready & !out_last. out_index increments.
//   - SEND -> IDLE: out_valid & out_ready & out_last.
// - eff_count = min(in_count, DEPTH). Counts above DEPTH are clamped, never wrapped.
// - Latency: first beat appears (out_valid=1, out_index=0) in the cycle after acceptance. One beat per cycle when out_ready is held at 1, so a list of N elements takes N cycles.
// - Handshake: out_valid never deasserts without a transfer. out_data, out_index and out_last are stable while out_valid & !out_ready.
// - out_data = snapshot[out_index]; out_last = (out_index == eff_count-1).
// - load_ready = (state==IDLE). No same-cycle reload: after the last beat, load_ready rises the next cycle.
// - load_valid while SEND: the input is ignored, the in-flight list is unaffected, and drop_pulse=1 in the next cycle (once per offending cycle).
// - Simultaneous last beat and load_valid: the load is dropped (the state is still SEND in that cycle), and drop_pulse fires.
// - rst asserted mid-SEND: the transfer is abandoned, the state goes to IDLE, and no out_last is produced.
// - Snapshot values are passed through unchanged; no re-sorting or dedup is done here.
// STRUCTURE
// - Shared package sort_pkg: WIDTH, DEPTH and CW constants, and the state encoding (IDLE=1'b0, SEND=1'b1). These are shared with the sort/dedup stage.
// - Single module; no sub-module. The snapshot is a DEPTH x WIDTH register array with an out_index read mux.
// TESTING
// - T1: Load {3,7,9,12,40}, count=5, out_ready=1 -> beats 3,7,9,12,40 on 5 consecutive cycles, index 0..4, out_last only on 40, then load_ready=1.
// - T2: Same list, out_ready toggled 1,0,0,1,... -> each beat is held stable while stalled, no beat is lost or duplicated, order is unchanged.
// - T3: count=0 -> empty_pulse for exactly 1 cycle, out_valid stays 0, state stays IDLE.
// - T4: count=15 with 9 values 1..9 -> exactly 9 beats (1..9), out_last on 9 (clamped).
// - T5: load_valid held high during a 4-beat send -> drop_pulse on every cycle after each busy cycle, the in-flight data is unchanged, and the next load is accepted only after the return to IDLE.
// - T6: rst=1 during the 3rd beat of 9 -> the next cycle has out_valid=0, busy=0, load_ready=1, and all outputs at their reset values.

Source files
------------

// File: rtl/sort_pkg.sv
// Constants and state encoding shared between the sort/dedup stage and the
// unique-list serializer.
package sort_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 9;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/unique_list_serializer_if.sv
// List-load port plus valid/ready element stream of the unique-list serializer.
// The slave modport is the serializer; the master modport is its environment.
interface unique_list_serializer_if
  import sort_pkg::*;
();

  logic                   load_valid;
  logic                   load_ready;
  logic [DEPTH*WIDTH-1:0] in_data;
  logic [CW-1:0]          in_count;

  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_data;
  logic [CW-1:0]          out_index;
  logic                   out_last;

  modport slave (
    input  load_valid, in_data, in_count, out_ready,
    output load_ready, out_valid, out_data, out_index, out_last
  );

  modport master (
    output load_valid, in_data, in_count, out_ready,
    input  load_ready, out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/unique_list_serializer.sv
// Captures a sorted, de-duplicated list into a snapshot and streams it out one
// element per beat; loads arriving mid-transfer are dropped and flagged.
module unique_list_serializer
  import sort_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  unique_list_serializer_if.slave  bus,
  output logic                     busy,
  output logic                     empty_pulse,
  output logic                     drop_pulse
);

  state_t           state_q, state_n;
  logic [WIDTH-1:0] snap_q [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    idx_q;
  logic [CW-1:0]    eff_count;
  logic             accept;
  logic             last_beat;

  // Oversized counts saturate at DEPTH rather than wrapping.
  assign eff_count = (bus.in_count > CW'(DEPTH)) ? CW'(DEPTH) : bus.in_count;
  assign accept    = bus.load_valid && (state_q == IDLE);
  assign last_beat = (state_q == SEND) && (idx_q == count_q - CW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // NOTE: state_n takes its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (accept && (eff_count != '0)) state_n = SEND;
      SEND: if (bus.out_ready && last_beat)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.load_ready = (state_q == IDLE);
    bus.out_valid  = (state_q == SEND);
    busy           = (state_q == SEND);
    bus.out_index  = idx_q;
    bus.out_last   = last_beat;
    bus.out_data   = (state_q == SEND) ? snap_q[idx_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the snapshot array is reset explicitly because its contents are
      // observable; a storage array that is never read before being written
      // would normally be left without reset.
      for (int k = 0; k < DEPTH; k++) snap_q[k] <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      empty_pulse <= 1'b0;
      drop_pulse  <= 1'b0;
    end else begin
      empty_pulse <= accept && (eff_count == '0);
      drop_pulse  <= bus.load_valid && (state_q == SEND);
      if (accept && (eff_count != '0)) begin
        for (int k = 0; k < DEPTH; k++) snap_q[k] <= bus.in_data[k*WIDTH +: WIDTH];
        count_q <= eff_count;
        idx_q   <= '0;
      end else if ((state_q == SEND) && bus.out_ready) begin
        idx_q <= last_beat ? '0 : idx_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_unique_list_serializer.sv
// Directed bench for unique_list_serializer: streaming, stalls, empty and
// clamped lists, drops while busy, and reset mid-transfer.
module tb_unique_list_serializer;
  import sort_pkg::*;

  typedef logic [WIDTH-1:0] list_t [DEPTH];

  logic clk;
  logic rst;
  logic busy;
  logic empty_pulse;
  logic drop_pulse;
  int   errors = 0;
  int   checks = 0;

  unique_list_serializer_if bus ();

  unique_list_serializer dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .busy        (busy),
    .empty_pulse (empty_pulse),
    .drop_pulse  (drop_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DEPTH*WIDTH-1:0] pack(input list_t v);
    logic [DEPTH*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) r[i*WIDTH +: WIDTH] = v[i];
    return r;
  endfunction

  // Presents one list for a single cycle, then clears the inputs so the
  // streamed data must come from the snapshot.
  task automatic load(input string tag, input list_t v, input logic [CW-1:0] n);
    bus.load_valid = 1'b1;
    bus.in_data    = pack(v);
    bus.in_count   = n;
    check({tag, "_load_ready"}, 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.in_data    = '0;
    bus.in_count   = '0;
  endtask

  // Receives n beats; stall=1 drives out_ready as 1,0,0,1,0,0,...
  task automatic drain(input string tag, input list_t v, input int n, input bit stall);
    int k;
    int c;
    k = 0;
    c = 0;
    while (k < n && c < 64) begin
      bus.out_ready = stall ? (c % 3 == 0) : 1'b1;
      check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_data"},  32'(bus.out_data),  32'(v[k]));
      check({tag, "_index"}, 32'(bus.out_index), 32'(k));
      check({tag, "_last"},  32'(bus.out_last),  32'(k == n - 1));
      check({tag, "_busy"},  32'(busy),          32'd1);
      if (bus.out_ready) k++;
      c++;
      @(negedge clk);
    end
    check({tag, "_beats"}, 32'(k), 32'(n));
    bus.out_ready = 1'b1;
    check({tag, "_done_valid"}, 32'(bus.out_valid),  32'd0);
    check({tag, "_done_ready"}, 32'(bus.load_ready), 32'd1);
    check({tag, "_done_busy"},  32'(busy),           32'd0);
  endtask

  list_t la, lb, lc, ld;

  initial begin
    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.in_data    = '0;
    bus.in_count   = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_load_ready", 32'(bus.load_ready), 32'd1);
    check("rst_out_valid",  32'(bus.out_valid),  32'd0);
    check("rst_out_data",   32'(bus.out_data),   32'd0);
    check("rst_out_index",  32'(bus.out_index),  32'd0);
    check("rst_out_last",   32'(bus.out_last),   32'd0);
    check("rst_busy",       32'(busy),           32'd0);
    check("rst_empty",      32'(empty_pulse),    32'd0);
    check("rst_drop",       32'(drop_pulse),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1: five elements, consumer always ready.
    la = '{8'd3, 8'd7, 8'd9, 8'd12, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0};
    load("t1", la, 4'd5);
    drain("t1", la, 5, 1'b0);

    // T2: same list with back-pressure.
    load("t2", la, 4'd5);
    drain("t2", la, 5, 1'b1);

    // T3: empty list is acknowledged by a single empty_pulse.
    load("t3", la, 4'd0);
    check("t3_empty",      32'(empty_pulse),    32'd1);
    check("t3_out_valid",  32'(bus.out_valid),  32'd0);
    check("t3_load_ready", 32'(bus.load_ready), 32'd1);
    check("t3_busy",       32'(busy),           32'd0);
    @(negedge clk);
    check("t3_empty_once", 32'(empty_pulse),    32'd0);
    check("t3_still_idle", 32'(bus.out_valid),  32'd0);

    // T4: count 15 clamps to nine elements.
    lb = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    load("t4", lb, 4'd15);
    drain("t4", lb, 9, 1'b0);

    // T5: load_valid held through a 4-beat send, including the last beat.
    lc = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    ld = '{8'd99, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bus.load_valid = 1'b1;
    bus.in_data    = pack(lc);
    bus.in_count   = 4'd4;
    @(negedge clk);
    bus.in_data  = pack(ld);
    bus.in_count = 4'd2;
    for (int c = 0; c < 4; c++) begin
      check("t5_valid", 32'(bus.out_valid),  32'd1);
      check("t5_data",  32'(bus.out_data),   32'(lc[c]));
      check("t5_index", 32'(bus.out_index),  32'(c));
      check("t5_last",  32'(bus.out_last),   32'(c == 3));
      check("t5_drop",  32'(drop_pulse),     32'(c > 0));
      check("t5_ready", 32'(bus.load_ready), 32'd0);
      @(negedge clk);
    end
    check("t5_idle_valid", 32'(bus.out_valid),  32'd0);
    check("t5_idle_ready", 32'(bus.load_ready), 32'd1);
    check("t5_last_drop",  32'(drop_pulse),     32'd1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    check("t5_reload_drop", 32'(drop_pulse), 32'd0);
    drain("t5b", ld, 2, 1'b0);

    // T6: reset during the third beat of nine.
    lb = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19};
    load("t6", lb, 4'd9);
    @(negedge clk);
    @(negedge clk);
    check("t6_beat3_data", 32'(bus.out_data), 32'd13);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_out_valid",  32'(bus.out_valid),  32'd0);
    check("t6_busy",       32'(busy),           32'd0);
    check("t6_load_ready", 32'(bus.load_ready), 32'd1);
    check("t6_out_data",   32'(bus.out_data),   32'd0);
    check("t6_out_index",  32'(bus.out_index),  32'd0);
    check("t6_out_last",   32'(bus.out_last),   32'd0);
    check("t6_empty",      32'(empty_pulse),    32'd0);
    check("t6_drop",       32'(drop_pulse),     32'd0);
    @(negedge clk);
    check("t6_stays_idle", 32'(bus.out_valid),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
